// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a small
// first-word-fall-through FIFO, with sticky frame-error and overrun flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_TICK = 176,
  parameter int FIFO_AW       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RX,
  input  logic               rd_en,
  input  logic               clr_err,
  output logic [7:0]         DATA,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               frame_err,
  output logic               overrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic               r_rx_meta;
  logic               r_rxs;
  logic [TW-1:0]      r_tick_cnt;
  state_t             r_state;
  logic [3:0]         r_os_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_frame_err;
  logic               r_overrun;

  logic w_tick;
  logic w_leave_idle;
  logic w_stop_sample;
  logic w_push;
  logic w_bad_stop;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr_ok;
  logic w_drop;

  assign w_tick        = (r_tick_cnt == TW'(CLKS_PER_TICK - 1));
  assign w_leave_idle  = (r_state == S_IDLE) && !r_rxs;
  assign w_stop_sample = (r_state == S_STOP) && w_tick && (r_os_cnt == 4'd15);
  assign w_push        = w_stop_sample && r_rxs;
  assign w_bad_stop    = w_stop_sample && !r_rxs;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_pop   = rd_en && !w_empty;
  // A push into a full FIFO is only accepted when the head leaves the same clock.
  assign w_wr_ok = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rxs     <= r_rx_meta;
    end
  end

  // Oversample tick divider, re-phased to the start edge when leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_leave_idle || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Receive FSM: mid-bit start validation, mid-bit data sampling, stop check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_os_cnt  <= 4'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_os_cnt <= 4'd0;
          if (!r_rxs) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_os_cnt == 4'd7) begin
              r_os_cnt  <= 4'd0;
              r_bit_idx <= 3'd0;
              // Line back high at mid start bit means a glitch, not a frame.
              r_state   <= r_rxs ? S_IDLE : S_DATA;
            end else begin
              r_os_cnt <= r_os_cnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_os_cnt == 4'd15) begin
              r_os_cnt  <= 4'd0;
              r_shift   <= {r_rxs, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
                r_state <= S_STOP;
              end
            end else begin
              r_os_cnt <= r_os_cnt + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_os_cnt == 4'd15) begin
              r_os_cnt <= 4'd0;
              r_state  <= r_rxs ? S_IDLE : S_BREAK;
            end else begin
              r_os_cnt <= r_os_cnt + 4'd1;
            end
          end
        end
        S_BREAK: begin
          // Hold here until the line releases so a stuck-low line flags once.
          r_os_cnt <= 4'd0;
          if (r_rxs) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_os_cnt <= 4'd0;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because DATA is gated by empty.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new set event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_bad_stop) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign DATA      = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with a fast tick
// (4 clks per tick, 64 clks per bit).
module tb_uart_rx_fifo;

  localparam int CPT = 4;
  localparam int AW  = 2;
  localparam int BIT = 16 * CPT;

  logic          clk;
  logic          rst;
  logic          RX;
  logic          rd_en;
  logic          clr_err;
  logic [7:0]    DATA;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          frame_err;
  logic          overrun;

  int n_assert;
  int n_fail;

  uart_rx_fifo #(
    .CLKS_PER_TICK (CPT),
    .FIFO_AW       (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .DATA      (DATA),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives start, 8 data bits and stop; returns one clk before the
  // receiver's stop-bit sample edge (34 clks into the stop bit).
  task automatic start_frame(input logic [7:0] d, input logic stop);
    @(posedge clk); #1; RX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(posedge clk);
      #1; RX = d[i];
    end
    repeat (BIT) @(posedge clk);
    #1; RX = stop;
    repeat (34) @(posedge clk);
    #1;
  endtask

  // Completes the stop bit and returns the line to idle.
  task automatic finish_frame(input int clks);
    repeat (clks) @(posedge clk);
    #1; RX = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    start_frame(d, stop);
    finish_frame(30);
  endtask

  task automatic pop;
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] d55;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1; RX = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Reset state
    check("rst_data", DATA, 8'h00);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);

    // 0xA5 with exact push latency
    start_frame(8'hA5, 1'b1);
    check("a5_pre_empty", empty, 1'b1);
    @(posedge clk); #1;
    check("a5_empty", empty, 1'b0);
    check("a5_count", count, 1);
    check("a5_data", DATA, 8'hA5);
    finish_frame(29);
    pop();
    check("a5_pop_empty", empty, 1'b1);
    check("a5_pop_data", DATA, 8'h00);

    // Short low glitch is rejected
    @(posedge clk); #1; RX = 1'b0;
    repeat (20) @(posedge clk);
    #1; RX = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("glitch_empty", empty, 1'b1);
    check("glitch_ferr", frame_err, 1'b0);

    // Framing error, then good byte, then clear
    send_byte(8'h3C, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("fe_flag", frame_err, 1'b1);
    check("fe_count", count, 0);
    send_byte(8'h81, 1'b1);
    check("fe_next_data", DATA, 8'h81);
    check("fe_still_set", frame_err, 1'b1);
    pop();
    pulse_clr();
    check("fe_cleared", frame_err, 1'b0);

    // Fill, overflow, drain
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i), 1'b1);
    end
    check("fill_full", full, 1'b1);
    check("fill_count", count, 4);
    check("fill_ovr0", overrun, 1'b0);
    send_byte(8'h05, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_count", count, 4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), DATA, 8'(i));
      pop();
    end
    check("drain_empty", empty, 1'b1);
    pulse_clr();
    check("ovr_cleared", overrun, 1'b0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1);
    end
    start_frame(8'h14, 1'b1);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("pp_ovr", overrun, 1'b0);
    check("pp_count", count, 4);
    check("pp_full", full, 1'b1);
    finish_frame(29);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("pp_order_%0d", i), DATA, 8'h10 + 8'(i));
      pop();
    end
    check("pp_empty", empty, 1'b1);

    // Reset in the middle of a frame
    send_byte(8'h77, 1'b1);
    check("mid_pre_count", count, 1);
    d55 = 8'h55;
    @(posedge clk); #1; RX = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (BIT) @(posedge clk);
      #1; RX = d55[i];
    end
    repeat (20) @(posedge clk);
    #1; rst = 1'b1; RX = 1'b1;
    #2;
    check("mid_rst_data", DATA, 8'h00);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_full", full, 1'b0);
    check("mid_rst_count", count, 0);
    check("mid_rst_ferr", frame_err, 1'b0);
    check("mid_rst_ovr", overrun, 1'b0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send_byte(8'h66, 1'b1);
    check("post_rst_data", DATA, 8'h66);
    check("post_rst_count", count, 1);
    check("post_rst_ferr", frame_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 16x-oversampled UART receiver for 8N1 serial data, default 9600 baud from the 27 MHz system clock.
- Validates the start bit at mid-bit, samples each data bit at mid-bit, and checks the stop bit.
- Received bytes go into a small first-word-fall-through FIFO, so the CPU-side logic can drain bytes at its own pace.
- Receiving end paired with the existing serial transmitter; replaces single-byte capture where burst traffic must not be lost.

Parameters:
- CLKS_PER_TICK, 176, system clocks per 1/16 bit time (27 MHz / (9600*16) rounded).
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clk  input  1  system clock, 27 MHz.
- rst  input  1  reset, asynchronous, active-high.
- RX  input  1  serial line, idle high; asynchronous to clk.
- rd_en  input  1  pop the FIFO head this cycle; ignored when empty=1.
- clr_err  input  1  one-cycle pulse clearing frame_err and overrun.
- DATA  output  8  FIFO head byte, valid while empty=0; 8'h00 when empty.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds 2**FIFO_AW bytes.
- count  output  FIFO_AW+1  bytes held, 0..2**FIFO_AW.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte arrived while the FIFO was full and was dropped.

Behaviour:
- Reset (async) values:
  - DATA=0, empty=1, full=0, count=0, frame_err=0, overrun=0.
  - FSM in IDLE; all counters at 0; synchronizer flops at 1.
- RX passes through a 2-flop synchronizer with reset value 1. Only the synchronized bit rxs is used.
- Tick generator:
  - Counter runs 0..CLKS_PER_TICK-1 and asserts a one-clk tick when it equals CLKS_PER_TICK-1.
  - It is forced to 0 on the clk the FSM leaves IDLE, so sampling is phase-aligned to the start edge.
- os_cnt (4 bit) increments on every tick. It is cleared on each state transition and after every sampled bit.
- FSM states:
  - IDLE: rxs==0 -> START.
  - START: on tick with os_cnt==7:
    - rxs==0 -> DATA, bit_idx=0.
    - rxs==1 -> IDLE (glitch rejected; nothing pushed; no flag set).
  - DATA: on tick with os_cnt==15, shift rxs in LSB-first. After bit_idx==7 is sampled -> STOP.
  - STOP: on tick with os_cnt==15:
    - rxs==1 -> push byte, then IDLE.
    - rxs==0 -> set frame_err, discard byte, go to BREAK.
  - BREAK: wait for rxs==1 -> IDLE. A held-low line produces exactly one frame_err, not repeated frames.
- Latency: the pushed byte appears on DATA with empty=0 on the clk after the stop-bit sample tick.
- FIFO:
  - Write pointer and read pointer of FIFO_AW bits wrap modulo depth; count is held separately.
  - Push and pop in the same clk: both occur and count is unchanged. This also holds when full; the byte is accepted and no overrun is set.
  - Push when full with no pop: byte dropped, overrun=1, FIFO contents unchanged.
  - rd_en when empty: no effect; count never underflows.
  - DATA shows mem[rd_ptr] combinationally from registered state while empty=0; 8'h00 otherwise.
- Sticky flags:
  - clr_err clears both flags.
  - A set event in the same clk as clr_err wins, and the flag stays 1.
- Reset asserted mid-frame: the frame is abandoned, the FIFO is emptied, and the receiver returns to IDLE. After release, the first falling edge begins a fresh frame.

Test Plan (CLKS_PER_TICK=4 for sim speed; bit time = 64 clks):
- Send 8N1 byte 0xA5 -> one clk after the stop-bit sample: empty=0, count=1, DATA=0xA5; pulse rd_en -> empty=1, DATA=0x00.
- RX low pulse of 20 clks, then high -> FSM returns to IDLE; empty stays 1, frame_err=0.
- Send 0x3C with the stop bit driven low, then idle high -> frame_err=1, count=0. Then send 0x81 -> DATA=0x81, frame_err still 1. Pulse clr_err -> frame_err=0.
- Send 0x01,0x02,0x03,0x04,0x05 with no reads -> full=1 after the 4th byte; 5th byte dropped with overrun=1. Pop 4 times -> 0x01,0x02,0x03,0x04 in order, then empty=1.
- Fill to full, then assert rd_en on the same clk as the 5th push -> overrun=0, count stays 4, the read order ends with the 5th byte.
- Assert rst during data bit 3 of 0x55 -> all outputs at reset values. Send 0x66 after release -> DATA=0x66, count=1.
